mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, 16-bit, byte-addressed memory between two requesters: a data port (D) and an instruction-fetch port (F).
- The memory reads combinationally, writes on the rising clock edge, and does not allow a read and a write in the same cycle.
- This block does the arbitration, inserts programmable wait states to model a slower memory, and returns the read data and completion to the winning requester.
- It sits between the pipeline's fetch/memory stages and the memory instance.

Parameters:
- ADDR_WIDTH, 16: address width; matches the memory.
- WAIT_CYCLES, 2: extra idle cycles before the memory access cycle. Legal range 0-15.
- STARVE_LIMIT, 4: maximum number of consecutive D grants while F is pending. Legal range 1-15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- d_req  in  1  data request; level, held until d_done.
- d_wr  in  1  1 = write, 0 = read; sampled at acceptance.
- d_addr  in  ADDR_WIDTH  byte address; sampled at acceptance.
- d_wdata  in  16  write data; sampled at acceptance.
- d_gnt  out  1  one-cycle pulse in the cycle D is accepted.
- d_done  out  1  one-cycle completion pulse.
- d_err  out  1  pulses with d_done when the address is misaligned.
- d_rdata  out  16  read data; valid with d_done and held until D's next read completes.
- f_req  in  1  fetch request (read only); level, held until f_done.
- f_addr  in  ADDR_WIDTH  fetch byte address.
- f_gnt / f_done / f_err  out  1 each  same rules as the D port.
- f_rdata  out  16  fetch data; same rules as d_rdata.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  combinational read data from the memory.

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE; wait counter = 0; starve counter = 0. All outputs go to 0, including both rdata registers and every mem_* output. An access in flight is abandoned and no write reaches memory.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - Arbitration happens when at least one req=1.
  - Only D requesting: D wins. Only F requesting: F wins.
  - Both requesting: D wins unless starve_cnt==STARVE_LIMIT, in which case F wins.
  - The winner's gnt pulses. Its addr, wr (forced 0 for F), wdata and owner are latched.
  - Next state is WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise ACCESS.
- Starve counter:
  - Increments when D is granted while f_req=1, saturating at STARVE_LIMIT.
  - Clears when F is granted, or when f_req=0 in IDLE.
- WAIT: cnt decrements each cycle; moves to ACCESS when cnt==0. All mem_* outputs stay 0.
- ACCESS (exactly one cycle):
  - Aligned address (addr[0]=0): mem_enable=1, mem_wr=latched wr, mem_addr and mem_data_in driven from the latch. On a read, mem_data_out is captured into the owner's rdata at the closing edge. On a write, rdata is unchanged.
  - Misaligned address (addr[0]=1): mem_enable=0, rdata unchanged, err flag set.
  - Next state is IDLE.
  - done (and err if set) for the owner is registered and pulses in the following cycle.
- mem_* outputs are nonzero only in ACCESS, so memory sees exactly one enable per transaction and never a read and write together.
- Latency: gnt in cycle T, memory access in T+1+WAIT_CYCLES, done in T+2+WAIT_CYCLES.
- Back-to-back: the FSM is in IDLE during the done cycle, so a new grant can occur in that same cycle. Peak throughput is one access per WAIT_CYCLES+2 cycles.
- Request changes after acceptance are ignored. A requester must not drop req before done; if it does, the transaction still completes.
- Simultaneous arrival of d_req and f_req in IDLE is resolved by the priority rule above; the loser's req stays pending.

Test Plan:
- WAIT_CYCLES=2. D writes 0xBEEF to 0x0010, then reads 0x0010 -> mem_enable high for exactly one cycle per access, each d_done 4 cycles after its d_gnt, d_rdata=0xBEEF.
- F reads 0x0004 while memory preloaded with 0x1234 at word 2 -> f_gnt, then f_done 4 cycles later, f_rdata=0x1234, d_* outputs stay 0.
- d_req and f_req held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; no mem cycle has both requesters' data.
- d_addr=0x0011 write -> d_done and d_err pulse together, mem_enable never asserts, memory word 8 unchanged.
- Assert rst=0 mid-WAIT on a D write to 0x0020 -> all outputs 0 immediately; no d_done; memory word 0x10 unchanged; after release, the FSM accepts a new request normally.
- WAIT_CYCLES=0 back-to-back F reads of 0x0000 and 0x0002 -> f_done in cycles T+2 and T+4, second f_gnt coincides with first f_done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port 16-bit memory: the data port has priority
// over instruction fetch (bounded by a starvation limit), with programmable wait states per access.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic                  d_err,
  output logic [15:0]           d_rdata,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_done,
  output logic                  f_err,
  output logic [15:0]           f_rdata,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [3:0] WAIT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
  localparam state_t     AFTER_GRANT = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [3:0]            starve_cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_wr;
  logic [15:0]           lat_wdata;
  logic                  owner_f;

  logic                  accept;
  logic                  pick_f;
  logic                  to_access;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_wr;
  logic [15:0]           win_wdata;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_wr;
  logic [15:0]           acc_wdata;

  // Grants are decided combinationally in IDLE so a new request can be accepted in the
  // same cycle the previous done pulses. Gating with rst keeps every output low in reset.
  always_comb begin
    pick_f    = f_req && (!d_req || (starve_cnt == STARVE_MAX));
    accept    = rst && (state == S_IDLE) && (d_req || f_req);
    d_gnt     = accept && !pick_f;
    f_gnt     = accept && pick_f;
    win_addr  = pick_f ? f_addr : d_addr;
    win_wr    = !pick_f && d_wr;
    win_wdata = pick_f ? 16'h0000 : d_wdata;
    if (state == S_IDLE) begin
      to_access = accept && (WAIT_CYCLES == 0);
      acc_addr  = win_addr;
      acc_wr    = win_wr;
      acc_wdata = win_wdata;
    end else begin
      to_access = (state == S_WAIT) && (wait_cnt == 4'd0);
      acc_addr  = lat_addr;
      acc_wr    = lat_wr;
      acc_wdata = lat_wdata;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create ordering-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      starve_cnt  <= 4'd0;
      lat_addr    <= '0;
      lat_wr      <= 1'b0;
      lat_wdata   <= 16'h0000;
      owner_f     <= 1'b0;
      d_done      <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= 16'h0000;
      f_done      <= 1'b0;
      f_err       <= 1'b0;
      f_rdata     <= 16'h0000;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= 16'h0000;
    end else begin
      d_done      <= 1'b0;
      d_err       <= 1'b0;
      f_done      <= 1'b0;
      f_err       <= 1'b0;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= 16'h0000;

      // Memory strobes are registered on entry to ACCESS; misaligned accesses never enable.
      if (to_access && !acc_addr[0]) begin
        mem_enable  <= 1'b1;
        mem_wr      <= acc_wr;
        mem_addr    <= acc_addr;
        mem_data_in <= acc_wdata;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_addr  <= win_addr;
            lat_wr    <= win_wr;
            lat_wdata <= win_wdata;
            owner_f   <= pick_f;
            wait_cnt  <= WAIT_INIT;
            state     <= AFTER_GRANT;
            if (pick_f || !f_req) starve_cnt <= 4'd0;
            else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
          end else if (!f_req) begin
            starve_cnt <= 4'd0;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_ACCESS;
          else wait_cnt <= wait_cnt - 4'd1;
        end
        S_ACCESS: begin
          state <= S_IDLE;
          if (owner_f) begin
            f_done <= 1'b1;
            f_err  <= lat_addr[0];
            if (!lat_addr[0]) f_rdata <= mem_data_out;
          end else begin
            d_done <= 1'b1;
            d_err  <= lat_addr[0];
            if (!lat_addr[0] && !lat_wr) d_rdata <= mem_data_out;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
